// File: rtl/debug_dm_regs_if.sv
// DMI strobe/read-data bus from the DTM plus the abstract-command register port into the hart.
// Modport slave is the debug module side, master is the DTM/hart side.
interface debug_dm_regs_if;
    logic        dmi_en;
    logic        dmi_wr;
    logic        dmi_rd;
    logic [7:0]  dmi_ad;
    logic [31:0] dmi_do;
    logic [31:0] dmi_di;
    logic        reg_req;
    logic        reg_we;
    logic [15:0] reg_ad;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport slave (
        input  dmi_en, dmi_wr, dmi_rd, dmi_ad, dmi_do,
        output dmi_di,
        output reg_req, reg_we, reg_ad, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport master (
        output dmi_en, dmi_wr, dmi_rd, dmi_ad, dmi_do,
        input  dmi_di,
        input  reg_req, reg_we, reg_ad, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/debug_dm_regs.sv
// RISC-V debug module register block: DMI decode, halt/resume control, one abstract register access at a time.
// Read data lands one edge after the strobe; the hart port holds REQ until ACK or the timeout counter expires.
module debug_dm_regs #(
    parameter logic [31:0] HARTINFO_VALUE = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    debug_dm_regs_if.slave dm_if,
    output logic           halt_req_o,
    output logic           resume_req_o,
    output logic           ndm_reset_o,
    input  logic           hart_halted_i,
    input  logic           hart_resumeack_i
);
    typedef enum logic {IDLE, REQ} state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        dmactive_q, dmactive_d;
    logic        haltreq_q, haltreq_d;
    logic        ndmreset_q, ndmreset_d;
    logic        resume_req_q, resume_req_d;
    logic        resumeack_q, resumeack_d;
    logic [31:0] data0_q, data0_d;
    logic [31:0] data1_q, data1_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        reg_we_q, reg_we_d;
    logic [15:0] reg_ad_q, reg_ad_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic [31:0] dmi_di_q, dmi_di_d;

    logic        wr, rd, busy;
    logic [31:0] wdat, rd_val;

    assign wr   = dm_if.dmi_en & dm_if.dmi_wr;
    assign rd   = dm_if.dmi_en & dm_if.dmi_rd & ~wr;
    assign wdat = dm_if.dmi_do;
    assign busy = (state_q == REQ);

    always_comb begin
        rd_val = '0;
        case (dm_if.dmi_ad)
            8'h04:   rd_val = data0_q;
            8'h05:   rd_val = data1_q;
            8'h10:   rd_val = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
            8'h11:   rd_val = {14'd0, {2{resumeack_q}}, 4'd0, {2{~hart_halted_i}},
                               {2{hart_halted_i}}, 4'h8, 4'h2};
            8'h12:   rd_val = HARTINFO_VALUE;
            8'h16:   rd_val = {19'd0, busy, 1'b0, cmderr_q, 4'd0, 4'h2};
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmactive_d   = dmactive_q;
        haltreq_d    = haltreq_q;
        ndmreset_d   = ndmreset_q;
        resume_req_d = resume_req_q;
        resumeack_d  = resumeack_q;
        data0_d      = data0_q;
        data1_d      = data1_q;
        cmderr_d     = cmderr_q;
        cnt_d        = cnt_q;
        reg_we_d     = reg_we_q;
        reg_ad_d     = reg_ad_q;
        reg_wdata_d  = reg_wdata_q;
        dmi_di_d     = dmi_di_q;

        if (rd) dmi_di_d = rd_val;

        if (hart_resumeack_i) begin
            resume_req_d = 1'b0;
            resumeack_d  = 1'b1;
        end

        if (wr) begin
            case (dm_if.dmi_ad)
                8'h10: begin
                    dmactive_d = wdat[0];
                    ndmreset_d = wdat[1];
                    haltreq_d  = wdat[31];
                    if (wdat[30] && !wdat[31]) begin
                        resume_req_d = 1'b1;
                        resumeack_d  = 1'b0;
                    end
                end
                8'h04: begin
                    if (!busy)                 data0_d  = wdat;
                    else if (cmderr_q == 3'd0) cmderr_d = 3'd1;
                end
                8'h05: begin
                    if (!busy)                 data1_d  = wdat;
                    else if (cmderr_q == 3'd0) cmderr_d = 3'd1;
                end
                8'h16: cmderr_d = cmderr_q & ~wdat[10:8];
                8'h17: begin
                    // first matching check wins; a sticky error blocks every later command
                    if (busy)                                            cmderr_d = 3'd1;
                    else if (cmderr_q != 3'd0)                           cmderr_d = cmderr_q;
                    else if (wdat[31:24] != 8'd0 || wdat[22:20] != 3'd2) cmderr_d = 3'd2;
                    else if (!hart_halted_i)                             cmderr_d = 3'd4;
                    else if (wdat[17]) begin
                        state_d     = REQ;
                        cnt_d       = 8'd0;
                        reg_we_d    = wdat[16];
                        reg_ad_d    = wdat[15:0];
                        reg_wdata_d = data0_q;
                    end
                end
                default: ;
            endcase
        end

        if (state_q == REQ) begin
            if (dm_if.reg_ack) begin
                state_d = IDLE;
                if (!reg_we_q) data0_d = dm_if.reg_rdata;
            end else if (cnt_q == TIMEOUT_LAST) begin
                state_d  = IDLE;
                cmderr_d = 3'd3;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        // an inactive DM holds everything but the DMI read register in reset
        if (!dmactive_d) begin
            state_d      = IDLE;
            haltreq_d    = 1'b0;
            ndmreset_d   = 1'b0;
            resume_req_d = 1'b0;
            resumeack_d  = 1'b0;
            data0_d      = '0;
            data1_d      = '0;
            cmderr_d     = '0;
            cnt_d        = '0;
            reg_we_d     = 1'b0;
            reg_ad_d     = '0;
            reg_wdata_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            dmactive_q   <= 1'b0;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            resume_req_q <= 1'b0;
            resumeack_q  <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            cmderr_q     <= '0;
            cnt_q        <= '0;
            reg_we_q     <= 1'b0;
            reg_ad_q     <= '0;
            reg_wdata_q  <= '0;
            dmi_di_q     <= '0;
        end else begin
            state_q      <= state_d;
            dmactive_q   <= dmactive_d;
            haltreq_q    <= haltreq_d;
            ndmreset_q   <= ndmreset_d;
            resume_req_q <= resume_req_d;
            resumeack_q  <= resumeack_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            cmderr_q     <= cmderr_d;
            cnt_q        <= cnt_d;
            reg_we_q     <= reg_we_d;
            reg_ad_q     <= reg_ad_d;
            reg_wdata_q  <= reg_wdata_d;
            dmi_di_q     <= dmi_di_d;
        end
    end

    assign dm_if.dmi_di    = dmi_di_q;
    assign dm_if.reg_req   = busy;
    assign dm_if.reg_we    = reg_we_q;
    assign dm_if.reg_ad    = reg_ad_q;
    assign dm_if.reg_wdata = reg_wdata_q;
    assign halt_req_o      = haltreq_q;
    assign resume_req_o    = resume_req_q;
    assign ndm_reset_o     = ndmreset_q;
endmodule

// File: tb/tb_debug_dm_regs.sv
// Bench for debug_dm_regs: directed scenarios plus a randomized DMI/hart sequence against a transaction-level model.
module tb_debug_dm_regs;
    localparam logic [31:0] HINFO = 32'h00A5_0011;
    localparam int          TMO   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic halt_req, resume_req, ndm_reset;
    logic hart_halted    = 1'b0;
    logic hart_resumeack = 1'b0;
    int   total = 0;
    int   bad   = 0;

    debug_dm_regs_if dm_if ();

    debug_dm_regs #(.HARTINFO_VALUE(HINFO), .ACK_TIMEOUT(TMO)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .dm_if            (dm_if),
        .halt_req_o       (halt_req),
        .resume_req_o     (resume_req),
        .ndm_reset_o      (ndm_reset),
        .hart_halted_i    (hart_halted),
        .hart_resumeack_i (hart_resumeack)
    );

    always #5 clk = ~clk;

    // transaction-level model of the architectural DM state
    bit          m_active, m_halt, m_ndm, m_resreq, m_resack, m_busy, m_we;
    bit [2:0]    m_err;
    bit [15:0]   m_ad;
    bit [31:0]   m_d0, m_d1, m_wd;
    logic [7:0]  serve_ops [4] = '{8'h04, 8'h05, 8'h16, 8'h17};
    logic [7:0]  rd_addrs  [7] = '{8'h04, 8'h05, 8'h10, 8'h11, 8'h12, 8'h16, 8'h17};

    function automatic void model_reset();
        m_active = 0; m_halt = 0; m_ndm = 0; m_resreq = 0; m_resack = 0;
        m_busy = 0; m_we = 0; m_err = 0; m_ad = 0; m_d0 = 0; m_d1 = 0; m_wd = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h04: return m_d0;
            8'h05: return m_d1;
            8'h10: return (m_halt ? 32'h8000_0000 : 32'h0) | (m_ndm ? 32'h2 : 32'h0) | (m_active ? 32'h1 : 32'h0);
            8'h11: return 32'h82 | (hart_halted ? 32'h300 : 32'hC00) | (m_resack ? 32'h3_0000 : 32'h0);
            8'h12: return HINFO;
            8'h16: return 32'h2 | (32'(m_err) * 256) | (m_busy ? 32'h1000 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
        if (a == 8'h10) begin
            m_active = d[0]; m_halt = d[31]; m_ndm = d[1];
            if (d[30] && !d[31]) begin m_resreq = 1; m_resack = 0; end
            if (!m_active) model_reset();
            return;
        end
        if (!m_active) return;
        case (a)
            8'h04: if (m_busy) begin if (m_err == 0) m_err = 1; end else m_d0 = d;
            8'h05: if (m_busy) begin if (m_err == 0) m_err = 1; end else m_d1 = d;
            8'h16: m_err = m_err & ~d[10:8];
            8'h17: begin
                if (m_busy) m_err = 1;
                else if (m_err != 0) begin end
                else if (d[31:24] != 0 || d[22:20] != 3'd2) m_err = 2;
                else if (!hart_halted) m_err = 4;
                else if (d[17]) begin m_busy = 1; m_we = d[16]; m_ad = d[15:0]; m_wd = m_d0; end
            end
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dmi_write(input logic [7:0] a, input logic [31:0] d);
        dm_if.dmi_en = 1'b1; dm_if.dmi_wr = 1'b1; dm_if.dmi_ad = a; dm_if.dmi_do = d;
        tick();
        dm_if.dmi_en = 1'b0; dm_if.dmi_wr = 1'b0;
        model_write(a, d);
    endtask

    task automatic dmi_read(input logic [7:0] a, output logic [31:0] v);
        dm_if.dmi_en = 1'b1; dm_if.dmi_rd = 1'b1; dm_if.dmi_ad = a;
        tick();
        dm_if.dmi_en = 1'b0; dm_if.dmi_rd = 1'b0;
        v = dm_if.dmi_di;
    endtask

    task automatic pulse_resumeack();
        hart_resumeack = 1'b1;
        tick();
        hart_resumeack = 1'b0;
        if (m_active) begin m_resack = 1; m_resreq = 0; end
    endtask

    // Acts as the hart: ACK in REQ cycle d (0-based), optionally one DMI write in REQ cycle op_cyc.
    task automatic hart_serve(input int d, input logic [31:0] rd_dat, input int op_cyc,
                              input logic [7:0] op_ad, input logic [31:0] op_dat);
        int k;
        k = 0;
        while (m_busy && k < 300) begin
            total++;
            if (dm_if.reg_req !== 1'b1 || dm_if.reg_we !== m_we || dm_if.reg_ad !== m_ad || dm_if.reg_wdata !== m_wd) begin
                bad++;
                $display("FAIL req_cycle%0d: req=%b we=%b ad=%h wd=%h, want req=1 we=%b ad=%h wd=%h",
                         k, dm_if.reg_req, dm_if.reg_we, dm_if.reg_ad, dm_if.reg_wdata, m_we, m_ad, m_wd);
            end
            if (k == d) begin dm_if.reg_ack = 1'b1; dm_if.reg_rdata = rd_dat; end
            if (k == op_cyc) begin
                dm_if.dmi_en = 1'b1; dm_if.dmi_wr = 1'b1; dm_if.dmi_ad = op_ad; dm_if.dmi_do = op_dat;
            end
            tick();
            dm_if.reg_ack = 1'b0; dm_if.reg_rdata = $urandom();
            dm_if.dmi_en = 1'b0; dm_if.dmi_wr = 1'b0;
            if (k == op_cyc) model_write(op_ad, op_dat);
            if (m_busy) begin
                if (k == d) begin m_busy = 0; if (!m_we) m_d0 = rd_dat; end
                else if (k + 1 == TMO) begin m_busy = 0; m_err = 3; end
            end
            k++;
        end
        total++;
        if (dm_if.reg_req !== 1'b0) begin bad++; $display("FAIL req_release: req=%b want 0", dm_if.reg_req); end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        dm_if.dmi_en = 0; dm_if.dmi_wr = 0; dm_if.dmi_rd = 0; dm_if.dmi_ad = 0; dm_if.dmi_do = 0;
        dm_if.reg_ack = 0; dm_if.reg_rdata = 0;
        #2 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        total++;
        if ({halt_req, resume_req, ndm_reset, dm_if.reg_req, dm_if.reg_we} !== 5'b0 ||
            dm_if.reg_ad !== 16'h0 || dm_if.reg_wdata !== 32'h0 || dm_if.dmi_di !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: pins=%b ad=%h wd=%h di=%h want all 0",
                     {halt_req, resume_req, ndm_reset, dm_if.reg_req, dm_if.reg_we}, dm_if.reg_ad, dm_if.reg_wdata, dm_if.dmi_di);
        end
        dmi_read(8'h11, v); total++;
        if (v !== 32'h0000_0C82) begin bad++; $display("FAIL dmstatus_reset: got %h want 00000c82", v); end
        dmi_read(8'h16, v); total++;
        if (v !== 32'h0000_0002) begin bad++; $display("FAIL abstractcs_reset: got %h want 00000002", v); end
        dmi_read(8'h12, v); total++;
        if (v !== HINFO) begin bad++; $display("FAIL hartinfo: got %h want %h", v, HINFO); end
        dmi_read(8'h10, v); total++;
        if (v !== 32'h0) begin bad++; $display("FAIL dmcontrol_reset: got %h want 0", v); end
    endtask

    task automatic test_halt();
        logic [31:0] v;
        dmi_write(8'h10, 32'h8000_0001); total++;
        if (halt_req !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", halt_req); end
        hart_halted = 1'b1;
        dmi_read(8'h11, v); total++;
        if (v !== 32'h0000_0382) begin bad++; $display("FAIL dmstatus_halted: got %h want 00000382", v); end
        dmi_write(8'h10, 32'h0000_0001); total++;
        if (halt_req !== 1'b0) begin bad++; $display("FAIL halt_clear: got %b want 0", halt_req); end
        dmi_write(8'h10, 32'h0000_0003);
        dmi_read(8'h10, v); total++;
        if (ndm_reset !== 1'b1 || v !== 32'h3) begin bad++; $display("FAIL ndmreset: pin=%b rd=%h want 1/00000003", ndm_reset, v); end
        dmi_write(8'h10, 32'h0000_0001);
    endtask

    task automatic test_resume();
        logic [31:0] v;
        dmi_write(8'h10, 32'h4000_0001);
        tick(); tick(); total++;
        if (resume_req !== 1'b1) begin bad++; $display("FAIL resume_level: got %b want 1", resume_req); end
        pulse_resumeack();
        dmi_read(8'h11, v); total++;
        if (resume_req !== 1'b0 || v !== 32'h0003_0382) begin bad++; $display("FAIL resume_ack: req=%b status=%h want 0/00030382", resume_req, v); end
        dmi_write(8'h10, 32'hC000_0001); total++;
        if (resume_req !== 1'b0 || halt_req !== 1'b1) begin bad++; $display("FAIL resume_with_halt: resume=%b halt=%b want 0/1", resume_req, halt_req); end
        dmi_write(8'h10, 32'h4000_0001);
        dmi_read(8'h11, v); total++;
        if (resume_req !== 1'b1 || v !== 32'h0000_0382) begin bad++; $display("FAIL resumeack_clear: req=%b status=%h want 1/00000382", resume_req, v); end
        pulse_resumeack();
    endtask

    task automatic test_cmd_write();
        logic [31:0] v;
        dmi_write(8'h04, 32'hDEAD_BEEF);
        dmi_write(8'h17, 32'h0023_1001); total++;
        if (dm_if.reg_req !== 1'b1 || dm_if.reg_we !== 1'b1 || dm_if.reg_ad !== 16'h1001 || dm_if.reg_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL cmd_write_launch: req=%b we=%b ad=%h wd=%h want 1/1/1001/deadbeef",
                     dm_if.reg_req, dm_if.reg_we, dm_if.reg_ad, dm_if.reg_wdata);
        end
        hart_serve(3, 32'h0, -1, 8'h00, 32'h0);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h2) begin bad++; $display("FAIL cmd_write_done: abstractcs=%h want 00000002", v); end
    endtask

    task automatic test_cmd_read();
        logic [31:0] v;
        dmi_write(8'h17, 32'h0022_1002); total++;
        if (dm_if.reg_req !== 1'b1 || dm_if.reg_we !== 1'b0) begin bad++; $display("FAIL cmd_read_launch: req=%b we=%b want 1/0", dm_if.reg_req, dm_if.reg_we); end
        hart_serve(1, 32'h1234_5678, -1, 8'h00, 32'h0);
        dmi_read(8'h04, v); total++;
        if (v !== 32'h1234_5678) begin bad++; $display("FAIL cmd_read_data0: got %h want 12345678", v); end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        dmi_write(8'h17, 32'h0022_1003);
        hart_serve(1000, 32'h0, -1, 8'h00, 32'h0);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h302) begin bad++; $display("FAIL timeout_err: abstractcs=%h want 00000302", v); end
        dmi_write(8'h17, 32'h0023_1004); total++;
        if (dm_if.reg_req !== 1'b0) begin bad++; $display("FAIL cmd_blocked: req=%b want 0", dm_if.reg_req); end
        dmi_write(8'h16, 32'h700);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h2) begin bad++; $display("FAIL cmderr_w1c: abstractcs=%h want 00000002", v); end
        dmi_write(8'h17, 32'h0023_1005);
        hart_serve(4, 32'h0, 1, 8'h04, 32'h5555_AAAA);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h102) begin bad++; $display("FAIL busy_data_write: abstractcs=%h want 00000102", v); end
        dmi_read(8'h04, v); total++;
        if (v !== 32'h1234_5678) begin bad++; $display("FAIL busy_data_kept: data0=%h want 12345678", v); end
        dmi_write(8'h16, 32'h100);
        dmi_write(8'h17, 32'h0022_1006);
        hart_serve(TMO - 1, 32'hCAFE_F00D, -1, 8'h00, 32'h0);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h2) begin bad++; $display("FAIL ack_beats_timeout: abstractcs=%h want 00000002", v); end
        dmi_read(8'h04, v); total++;
        if (v !== 32'hCAFE_F00D) begin bad++; $display("FAIL ack_last_data: data0=%h want cafef00d", v); end
    endtask

    task automatic test_dmactive();
        logic [31:0] v;
        dmi_write(8'h05, 32'h1111_2222);
        dmi_write(8'h17, 32'h0023_1007);
        hart_serve(1000, 32'h0, 2, 8'h10, 32'h0);
        dmi_read(8'h04, v); total++;
        if (v !== 32'h0) begin bad++; $display("FAIL inactive_data0: got %h want 0", v); end
        dmi_read(8'h05, v); total++;
        if (v !== 32'h0) begin bad++; $display("FAIL inactive_data1: got %h want 0", v); end
        dmi_read(8'h16, v); total++;
        if (v !== 32'h2) begin bad++; $display("FAIL inactive_abstractcs: got %h want 00000002", v); end
        dmi_write(8'h04, 32'h0000_0099);
        dmi_write(8'h10, 32'h1);
        dmi_read(8'h04, v); total++;
        if (v !== 32'h0) begin bad++; $display("FAIL inactive_write_ignored: data0=%h want 0", v); end
        dmi_write(8'h17, 32'h0033_1000);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h202) begin bad++; $display("FAIL bad_aarsize: abstractcs=%h want 00000202", v); end
        dmi_write(8'h16, 32'h700);
        hart_halted = 1'b0;
        dmi_write(8'h17, 32'h0023_1000);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h402) begin bad++; $display("FAIL hart_running: abstractcs=%h want 00000402", v); end
        dmi_write(8'h16, 32'h700);
        hart_halted = 1'b1;
        dmi_write(8'h17, 32'h0021_1000);
        dmi_read(8'h16, v); total++;
        if (v !== 32'h2 || dm_if.reg_req !== 1'b0) begin bad++; $display("FAIL no_transfer: abstractcs=%h req=%b want 00000002/0", v, dm_if.reg_req); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, w;
        dmi_write(8'h04, 32'hA0A0_0001);
        dmi_write(8'h05, 32'hB0B0_0002);
        dmi_read(8'h04, v);
        dmi_read(8'h05, w); total++;
        if (v !== 32'hA0A0_0001 || w !== 32'hB0B0_0002) begin bad++; $display("FAIL b2b_reads: got %h %h want a0a00001 b0b00002", v, w); end
        dm_if.dmi_en = 1'b1; dm_if.dmi_wr = 1'b1; dm_if.dmi_rd = 1'b1; dm_if.dmi_ad = 8'h05; dm_if.dmi_do = 32'hC0C0_0003;
        tick();
        dm_if.dmi_en = 1'b0; dm_if.dmi_wr = 1'b0; dm_if.dmi_rd = 1'b0;
        model_write(8'h05, 32'hC0C0_0003);
        tick(); tick(); total++;
        if (dm_if.dmi_di !== 32'hB0B0_0002) begin bad++; $display("FAIL write_wins_hold: di=%h want b0b00002", dm_if.dmi_di); end
        dmi_read(8'h05, v); total++;
        if (v !== 32'hC0C0_0003) begin bad++; $display("FAIL write_wins_data: data1=%h want c0c00003", v); end
        dmi_write(8'h13, 32'hFFFF_FFFF);
        dmi_read(8'h13, v);
        dmi_read(8'h17, w); total++;
        if (v !== 32'h0 || w !== 32'h0) begin bad++; $display("FAIL unmapped_reads: got %h %h want 0 0", v, w); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        dmi_write(8'h17, 32'h0022_1008);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1; total++;
        if (dm_if.reg_req !== 1'b0 || dm_if.reg_ad !== 16'h0 || halt_req !== 1'b0 || dm_if.dmi_di !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: req=%b ad=%h halt=%b di=%h want 0", dm_if.reg_req, dm_if.reg_ad, halt_req, dm_if.dmi_di);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        dm_if.reg_ack = 1'b1; dm_if.reg_rdata = 32'hBAD0_BAD0;
        tick();
        dm_if.reg_ack = 1'b0;
        dmi_write(8'h10, 32'h1);
        dmi_read(8'h04, v); total++;
        if (v !== 32'h0 || dm_if.reg_req !== 1'b0) begin bad++; $display("FAIL late_ack: data0=%h req=%b want 0/0", v, dm_if.reg_req); end
    endtask

    task automatic test_random();
        logic [31:0] v, exp, d;
        logic [7:0]  a;
        int          r;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                hart_halted = 1'($urandom_range(0, 1));
                tick();
            end else if (r < 35) begin
                r = $urandom_range(0, 7);
                a = (r == 7) ? 8'($urandom()) : rd_addrs[r];
                exp = model_read(a);
                dmi_read(a, v); total++;
                if (v !== exp) begin bad++; $display("FAIL rand_read@%h: got %h want %h", a, v, exp); end
            end else if (r < 48) begin
                dmi_write(($urandom_range(0, 1) == 0) ? 8'h04 : 8'h05, $urandom());
            end else if (r < 58) begin
                dmi_write(8'h16, ($urandom_range(0, 1) == 0) ? 32'h700 : $urandom());
            end else if (r < 63) begin
                d = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 28'd0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0)};
                dmi_write(8'h10, d);
            end else if (r < 68) begin
                pulse_resumeack();
            end else begin
                d = $urandom();
                d[31:24] = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : 8'd0;
                d[22:20] = ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'd2;
                d[17]    = ($urandom_range(0, 5) != 0);
                dmi_write(8'h17, d);
                if (m_busy)
                    hart_serve($urandom_range(0, TMO + 2), $urandom(),
                               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO)) : -1,
                               serve_ops[$urandom_range(0, 3)], $urandom());
            end
            total++;
            if ({halt_req, ndm_reset, resume_req, dm_if.reg_req} !== {m_halt, m_ndm, m_resreq, m_busy}) begin
                bad++;
                $display("FAIL rand_pins it%0d: halt/ndm/resume/req=%b want %b", it,
                         {halt_req, ndm_reset, resume_req, dm_if.reg_req}, {m_halt, m_ndm, m_resreq, m_busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_resume();
        test_cmd_write();
        test_cmd_read();
        test_timeout();
        test_dmactive();
        test_back_to_back();
        test_async_reset();
        hart_halted = 1'b1;
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
